// File: rtl/mux8_arbiter.sv
// Eight-way round-robin arbiter with a three-state grant FSM. It also provides a
// registered 8:1 data select of the grant holder's A bit.
module mux8_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Req,
  input  logic       Done,
  input  logic [7:0] A,
  output logic [2:0] Sel,
  output logic [7:0] Gnt,
  output logic       Valid,
  output logic       F,
  output logic       Busy,
  output logic       Timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [3:0] MAX_C = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;
  logic       f_q, f_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  // First set request bit, searching upward from last+1 with wrap 7->0.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
    logic [2:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (|Req) begin
          state_d = GRANT;
          sel_d   = rr_pick(Req, ptr_q);
          ptr_d   = sel_d;
          cnt_d   = 4'd1;
        end
      end
      GRANT: begin
        if (Done || !Req[sel_q] || (cnt_q == MAX_C)) begin
          state_d   = RELEASE;
          cnt_d     = 4'd0;
          // Only a hold-limit expiry with the requester still asking counts as a timeout.
          timeout_d = !Done && Req[sel_q];
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    gnt_d   = (state_d == GRANT) ? (8'b1 << sel_d) : 8'b0;
    valid_d = (state_d == GRANT);
    busy_d  = (state_d != IDLE);
    f_d     = (state_d == GRANT) ? A[sel_d] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 3'd0;
      ptr_q     <= 3'd7;
      cnt_q     <= 4'd0;
      gnt_q     <= 8'b0;
      valid_q   <= 1'b0;
      f_q       <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      f_q       <= f_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign Sel     = sel_q;
  assign Gnt     = gnt_q;
  assign Valid   = valid_q;
  assign F       = f_q;
  assign Busy    = busy_q;
  assign Timeout = timeout_q;

endmodule

// File: tb/tb_mux8_arbiter.sv
// Directed bench for mux8_arbiter (hold limit 4). Every output is compared as one packed word.
module tb_mux8_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] Req;
  logic       Done;
  logic [7:0] A;
  logic [2:0] Sel;
  logic [7:0] Gnt;
  logic       Valid, F, Busy, Timeout;

  int n_vec = 0;
  int n_bad = 0;

  mux8_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .Req(Req), .Done(Done), .A(A),
    .Sel(Sel), .Gnt(Gnt), .Valid(Valid), .F(F), .Busy(Busy), .Timeout(Timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input logic [2:0] s, input logic [7:0] g,
                                     input logic v, input logic f, input logic b, input logic t);
    pk = {s, g, v, f, b, t};
  endfunction

  function automatic logic [7:0] oh(input logic [2:0] s);
    oh = 8'b1 << s;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {Sel,Gnt,V,F,B,T}=%h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] obs();
    obs = {Sel, Gnt, Valid, F, Busy, Timeout};
  endfunction

  initial begin
    rst = 1'b1; Req = 8'h00; Done = 1'b0; A = 8'h00;
    tick();
    chk("reset", obs(), pk(3'd0, 8'h00, 0, 0, 0, 0));

    // Single requester 2
    rst = 1'b0; Req = 8'h04;
    tick();
    chk("grant2", obs(), pk(3'd2, 8'h04, 1, 0, 1, 0));
    Done = 1'b1;
    tick();
    chk("rel2", obs(), pk(3'd2, 8'h00, 0, 0, 1, 0));
    Done = 1'b0; Req = 8'h00;
    tick();
    chk("idle2", obs(), pk(3'd2, 8'h00, 0, 0, 0, 0));
    tick();
    chk("idle_noreq", obs(), pk(3'd2, 8'h00, 0, 0, 0, 0));

    // Full round-robin sweep from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0; Req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      logic [2:0] w;
      w = 3'(k % 8);
      tick();
      chk($sformatf("rr_grant%0d", k), obs(), pk(w, oh(w), 1, 0, 1, 0));
      Done = 1'b1;
      tick();
      chk($sformatf("rr_rel%0d", k), obs(), pk(w, 8'h00, 0, 0, 1, 0));
      Done = 1'b0;
      tick();
      chk($sformatf("rr_idle%0d", k), obs(), pk(w, 8'h00, 0, 0, 0, 0));
    end

    // Wrap from 6 through 7 to 0
    Req = 8'h40;
    tick();
    chk("grant6", obs(), pk(3'd6, 8'h40, 1, 0, 1, 0));
    Done = 1'b1;
    tick();
    Done = 1'b0; Req = 8'h00;
    tick();
    Req = 8'h41;
    tick();
    chk("wrap0", obs(), pk(3'd0, 8'h01, 1, 0, 1, 0));
    Done = 1'b1;
    tick();
    Done = 1'b0; Req = 8'h00;
    tick();

    // Hold limit timeout on requester 3; other Req bits change mid-grant
    Req = 8'h08;
    tick();
    chk("hold_c1", obs(), pk(3'd3, 8'h08, 1, 0, 1, 0));
    Req = 8'hF8;
    tick();
    chk("hold_c2", obs(), pk(3'd3, 8'h08, 1, 0, 1, 0));
    tick();
    chk("hold_c3", obs(), pk(3'd3, 8'h08, 1, 0, 1, 0));
    Req = 8'h08;
    tick();
    chk("hold_c4", obs(), pk(3'd3, 8'h08, 1, 0, 1, 0));
    tick();
    chk("timeout", obs(), pk(3'd3, 8'h00, 0, 0, 1, 1));
    tick();
    chk("to_idle", obs(), pk(3'd3, 8'h00, 0, 0, 0, 0));
    tick();
    chk("regrant3", obs(), pk(3'd3, 8'h08, 1, 0, 1, 0));
    Req = 8'h00;
    tick();
    chk("reqdrop_rel", obs(), pk(3'd3, 8'h00, 0, 0, 1, 0));
    tick();

    // Done coinciding with the hold limit gives no timeout
    Req = 8'h08;
    tick();
    tick();
    tick();
    tick();
    chk("done_at_max_c4", obs(), pk(3'd3, 8'h08, 1, 0, 1, 0));
    Done = 1'b1;
    tick();
    chk("done_at_max_rel", obs(), pk(3'd3, 8'h00, 0, 0, 1, 0));
    Done = 1'b0; Req = 8'h00;
    tick();

    // Data select: F follows A[5] only
    Req = 8'h20; A = 8'hDF;
    tick();
    chk("f_c1", obs(), pk(3'd5, 8'h20, 1, 0, 1, 0));
    A = 8'h20;
    tick();
    chk("f_c2", obs(), pk(3'd5, 8'h20, 1, 1, 1, 0));
    A = 8'h5A;
    tick();
    chk("f_c3", obs(), pk(3'd5, 8'h20, 1, 0, 1, 0));
    A = 8'hFF; Done = 1'b1;
    tick();
    chk("f_rel", obs(), pk(3'd5, 8'h00, 0, 0, 1, 0));
    Done = 1'b0; Req = 8'h00;
    tick();
    chk("f_idle", obs(), pk(3'd5, 8'h00, 0, 0, 0, 0));
    A = 8'h00;

    // Reset in the third GRANT cycle of a grant to 4
    Req = 8'h10;
    tick();
    tick();
    tick();
    chk("g4_c3", obs(), pk(3'd4, 8'h10, 1, 0, 1, 0));
    rst = 1'b1;
    tick();
    chk("mid_reset", obs(), pk(3'd0, 8'h00, 0, 0, 0, 0));
    rst = 1'b0; Req = 8'hFF;
    tick();
    chk("post_reset0", obs(), pk(3'd0, 8'h01, 1, 0, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
